// File: rtl/ntt_intt_ch_router.sv
// OBI front end that steers each transfer to one of NUM_CH accelerator channels and keeps responses in order.
// Also aggregates the per-channel interrupts behind a small register port.
module ntt_intt_ch_router #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned MAX_OUTST   = 4,
  parameter int unsigned CH_ADDR_LSB = 12,
  parameter logic [31:0] ERR_RDATA   = 32'hBADCAB1E
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                s_req_i,
  output logic                s_gnt_o,
  input  logic [31:0]         s_addr_i,
  input  logic                s_we_i,
  input  logic [3:0]          s_be_i,
  input  logic [31:0]         s_wdata_i,
  output logic                s_rvalid_o,
  output logic [31:0]         s_rdata_o,
  output logic [NUM_CH-1:0]   m_req_o,
  input  logic [NUM_CH-1:0]   m_gnt_i,
  output logic [31:0]         m_addr_o,
  output logic                m_we_o,
  output logic [3:0]          m_be_o,
  output logic [31:0]         m_wdata_o,
  input  logic [NUM_CH-1:0]   m_rvalid_i,
  input  logic [NUM_CH*32-1:0] m_rdata_i,
  input  logic [NUM_CH-1:0]   irq_i,
  output logic                irq_o,
  input  logic                reg_valid_i,
  input  logic                reg_write_i,
  input  logic [3:0]          reg_addr_i,
  input  logic [31:0]         reg_wdata_i,
  output logic [31:0]         reg_rdata_o,
  output logic                reg_error_o
);

  localparam int unsigned CNTW = (MAX_OUTST < 1) ? 1 : $clog2(MAX_OUTST + 1);
  localparam logic [4:0]  ERR_CH = 5'(NUM_CH);

  logic [CNTW-1:0]   r_cnt;
  logic [4:0]        r_cur;
  logic              r_err_rvalid;
  logic              r_stray;
  logic [NUM_CH-1:0] r_irq_q;
  logic [NUM_CH-1:0] r_pending;
  logic [NUM_CH-1:0] r_mask;
  logic              r_irq;

  logic [31:0]       w_idx;
  logic              w_miss;
  logic [4:0]        w_sel;
  logic              w_issue;
  logic              w_hs;
  logic [NUM_CH-1:0] w_cur_oh;
  logic              w_ch_rvalid;
  logic [31:0]       w_ch_rdata;
  logic              w_stray_set;
  logic              w_reg_wr;
  logic              w_off_pend;
  logic              w_off_mask;
  logic              w_off_status;
  logic [NUM_CH-1:0] w_irq_edge;
  logic [NUM_CH-1:0] w_w1c;
  logic [31:0]       w_status;
  logic              w_unused;

  // Any set address bit above the channel field is treated as a decode miss, not aliased.
  assign w_idx  = s_addr_i >> CH_ADDR_LSB;
  assign w_miss = (w_idx >= 32'(NUM_CH));
  assign w_sel  = w_miss ? ERR_CH : w_idx[4:0];

  assign w_issue = s_req_i && (r_cnt < CNTW'(MAX_OUTST)) &&
                   ((r_cnt == '0) || (w_sel == r_cur));

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign m_req_o[gi]  = w_issue && !w_miss && (w_sel == 5'(gi));
      assign w_cur_oh[gi] = (r_cnt != '0) && (r_cur == 5'(gi));
    end
  endgenerate

  assign s_gnt_o = w_issue && (w_miss || (|(m_req_o & m_gnt_i)));
  assign w_hs    = s_req_i && s_gnt_o;

  assign m_addr_o  = s_addr_i;
  assign m_we_o    = s_we_i;
  assign m_be_o    = s_be_i;
  assign m_wdata_o = s_wdata_i;

  always_comb begin
    w_ch_rdata = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_cur_oh[k]) begin
        w_ch_rdata = m_rdata_i[32*k +: 32];
      end
    end
  end

  assign w_ch_rvalid = |(m_rvalid_i & w_cur_oh);
  assign w_stray_set = |(m_rvalid_i & ~w_cur_oh);
  assign s_rvalid_o  = w_ch_rvalid || r_err_rvalid;
  assign s_rdata_o   = r_err_rvalid ? ERR_RDATA : (w_ch_rvalid ? w_ch_rdata : 32'h0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt        <= '0;
      r_cur        <= '0;
      r_err_rvalid <= 1'b0;
    end else begin
      r_err_rvalid <= w_hs && w_miss;
      if (w_hs) begin
        r_cur <= w_sel;
      end
      case ({w_hs, s_rvalid_o})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign w_reg_wr     = reg_valid_i && reg_write_i;
  assign w_off_pend   = (reg_addr_i == 4'h0);
  assign w_off_mask   = (reg_addr_i == 4'h4);
  assign w_off_status = (reg_addr_i == 4'h8);
  assign w_irq_edge   = irq_i & ~r_irq_q;
  assign w_w1c        = (w_reg_wr && w_off_pend) ? reg_wdata_i[NUM_CH-1:0] : '0;

  // A new edge in the same cycle as its W1C keeps the pending bit set.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_irq_q   <= '0;
      r_pending <= '0;
      r_mask    <= '0;
      r_irq     <= 1'b0;
      r_stray   <= 1'b0;
    end else begin
      r_irq_q   <= irq_i;
      r_pending <= (r_pending & ~w_w1c) | w_irq_edge;
      r_irq     <= |(r_pending & r_mask);
      if (w_reg_wr && w_off_mask) begin
        r_mask <= reg_wdata_i[NUM_CH-1:0];
      end
      r_stray <= w_stray_set || (r_stray && !(w_reg_wr && w_off_status));
    end
  end

  assign irq_o    = r_irq;
  assign w_status = {r_stray, 10'h0, r_cur, 8'h0, 8'(r_cnt)};

  always_comb begin
    reg_rdata_o = 32'h0;
    if (w_off_pend) begin
      reg_rdata_o = 32'(r_pending);
    end else if (w_off_mask) begin
      reg_rdata_o = 32'(r_mask);
    end else if (w_off_status) begin
      reg_rdata_o = w_status;
    end
  end

  assign reg_error_o = reg_valid_i && !(w_off_pend || w_off_mask || w_off_status);

  assign w_unused = ^reg_wdata_i[31:NUM_CH];

endmodule

// File: tb/tb_ntt_intt_ch_router.sv
// Bench for ntt_intt_ch_router: scoreboarded responses, channel model, IRQ and register checks.
module tb_ntt_intt_ch_router;

  localparam logic [31:0] ERR_RDATA = 32'hBADCAB1E;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         s_req_i;
  logic [31:0]  s_addr_i;
  logic         s_we_i;
  logic [3:0]   s_be_i;
  logic [31:0]  s_wdata_i;
  logic [3:0]   m_gnt_i;
  logic [3:0]   m_rvalid_i;
  logic [127:0] m_rdata_i;
  logic [3:0]   irq_i;
  logic         reg_valid_i;
  logic         reg_write_i;
  logic [3:0]   reg_addr_i;
  logic [31:0]  reg_wdata_i;

  logic         s_gnt_o, s_rvalid_o, irq_o, reg_error_o;
  logic [31:0]  s_rdata_o, m_addr_o, m_wdata_o, reg_rdata_o;
  logic [3:0]   m_req_o, m_be_o;
  logic         m_we_o;

  logic         d2_gnt, d2_rvalid, d2_irq, d2_rerr, d2_we;
  logic [31:0]  d2_rdata, d2_addr, d2_wdata, d2_reg;
  logic [3:0]   d2_req, d2_be;

  always #5 clk = ~clk;

  ntt_intt_ch_router u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .s_req_i(s_req_i), .s_gnt_o(s_gnt_o), .s_addr_i(s_addr_i), .s_we_i(s_we_i),
    .s_be_i(s_be_i), .s_wdata_i(s_wdata_i), .s_rvalid_o(s_rvalid_o), .s_rdata_o(s_rdata_o),
    .m_req_o(m_req_o), .m_gnt_i(m_gnt_i), .m_addr_o(m_addr_o), .m_we_o(m_we_o),
    .m_be_o(m_be_o), .m_wdata_o(m_wdata_o), .m_rvalid_i(m_rvalid_i), .m_rdata_i(m_rdata_i),
    .irq_i(irq_i), .irq_o(irq_o),
    .reg_valid_i(reg_valid_i), .reg_write_i(reg_write_i), .reg_addr_i(reg_addr_i),
    .reg_wdata_i(reg_wdata_i), .reg_rdata_o(reg_rdata_o), .reg_error_o(reg_error_o)
  );

  ntt_intt_ch_router #(.MAX_OUTST(2)) u_dut_m2 (
    .clk_i(clk), .rst_ni(rst_n),
    .s_req_i(s_req_i), .s_gnt_o(d2_gnt), .s_addr_i(s_addr_i), .s_we_i(s_we_i),
    .s_be_i(s_be_i), .s_wdata_i(s_wdata_i), .s_rvalid_o(d2_rvalid), .s_rdata_o(d2_rdata),
    .m_req_o(d2_req), .m_gnt_i(m_gnt_i), .m_addr_o(d2_addr), .m_we_o(d2_we),
    .m_be_o(d2_be), .m_wdata_o(d2_wdata), .m_rvalid_i(m_rvalid_i), .m_rdata_i(m_rdata_i),
    .irq_i(irq_i), .irq_o(d2_irq),
    .reg_valid_i(reg_valid_i), .reg_write_i(reg_write_i), .reg_addr_i(reg_addr_i),
    .reg_wdata_i(reg_wdata_i), .reg_rdata_o(d2_reg), .reg_error_o(d2_rerr)
  );

  typedef struct {
    int          ch;
    int          due;
    logic [31:0] data;
  } rsp_t;

  rsp_t        rsp_q[$];
  logic [31:0] sb[$];
  int          cyc;
  int          rsp_lat;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  logic        obs_gnt, obs_rvalid, obs_rerr, obs_irq, obs_gnt2, obs_rvalid2;
  logic [3:0]  obs_req;
  logic [31:0] obs_rdata, obs_reg, obs_rdata2;

  function automatic logic [31:0] chdata(input logic [31:0] a);
    return a ^ 32'hA5C3_0F00;
  endfunction

  // Channel model: releases scheduled responses, other lanes carry junk rdata.
  task automatic drive_rsp();
    rsp_t keep[$];
    m_rvalid_i = '0;
    for (int k = 0; k < 4; k++) m_rdata_i[32*k +: 32] = 32'hDEAD_0000 | 32'(k);
    foreach (rsp_q[i]) begin
      if (rsp_q[i].due == cyc) begin
        m_rvalid_i[rsp_q[i].ch] = 1'b1;
        m_rdata_i[32*rsp_q[i].ch +: 32] = rsp_q[i].data;
      end else begin
        keep.push_back(rsp_q[i]);
      end
    end
    rsp_q = keep;
  endtask

  task automatic inject(input int ch, input logic [31:0] d);
    m_rvalid_i[ch] = 1'b1;
    m_rdata_i[32*ch +: 32] = d;
  endtask

  task automatic tick();
    logic [31:0] idx;
    #1;
    obs_gnt = s_gnt_o;   obs_req = m_req_o;     obs_rvalid = s_rvalid_o; obs_rdata = s_rdata_o;
    obs_reg = reg_rdata_o; obs_rerr = reg_error_o; obs_irq = irq_o;
    obs_gnt2 = d2_gnt;   obs_rvalid2 = d2_rvalid; obs_rdata2 = d2_rdata;
    idx = s_addr_i >> 12;
    if (s_req_i && s_gnt_o) sb.push_back((idx >= 32'd4) ? ERR_RDATA : chdata(s_addr_i));
    for (int k = 0; k < 4; k++)
      if (m_req_o[k] && m_gnt_i[k] && rsp_lat > 0) rsp_q.push_back('{k, cyc + rsp_lat, chdata(s_addr_i)});
    @(posedge clk);
    #1;
    cyc++;
    drive_rsp();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    s_req_i = 0; s_addr_i = 0; s_we_i = 0; s_be_i = 4'hF; s_wdata_i = 0;
    m_gnt_i = 0; m_rvalid_i = 0; m_rdata_i = 0; irq_i = 0;
    reg_valid_i = 0; reg_write_i = 0; reg_addr_i = 4'h8; reg_wdata_i = 0;
    sb.delete(); rsp_q.delete(); rsp_lat = -1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    drive_rsp();
  endtask

  task automatic reg_write(input logic [3:0] a, input logic [31:0] d);
    reg_valid_i = 1; reg_write_i = 1; reg_addr_i = a; reg_wdata_i = d;
    tick();
    reg_valid_i = 0; reg_write_i = 0; reg_addr_i = 4'h8; reg_wdata_i = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total_cnt++; if ({s_gnt_o, s_rvalid_o, irq_o} !== 3'b000) $display("FAIL rst_ctrl: got %b want 000", {s_gnt_o, s_rvalid_o, irq_o}); else pass_cnt++;
    total_cnt++; if (s_rdata_o !== 32'h0) $display("FAIL rst_rdata: got %h want 0", s_rdata_o); else pass_cnt++;
    total_cnt++; if (m_req_o !== 4'h0) $display("FAIL rst_mreq: got %h want 0", m_req_o); else pass_cnt++;
    total_cnt++; if (reg_rdata_o !== 32'h0) $display("FAIL rst_status: got %h want 0", reg_rdata_o); else pass_cnt++;
    reg_addr_i = 4'h0; #1;
    total_cnt++; if (reg_rdata_o !== 32'h0) $display("FAIL rst_pending: got %h want 0", reg_rdata_o); else pass_cnt++;
    reg_addr_i = 4'h4; #1;
    total_cnt++; if (reg_rdata_o !== 32'h0) $display("FAIL rst_mask: got %h want 0", reg_rdata_o); else pass_cnt++;
    reg_addr_i = 4'h8;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    int peak = 0;
    int n = 0;
    do_reset();
    rsp_lat = 3; m_gnt_i = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      s_req_i = 1; s_addr_i = 32'h2000 + 32'(4 * i);
      tick();
      total_cnt++; if (obs_gnt !== 1'b1) $display("FAIL b2b_gnt%0d: got %b want 1", i, obs_gnt); else pass_cnt++;
      if (i == 0) begin
        total_cnt++; if (obs_req !== 4'b0100) $display("FAIL b2b_mreq: got %b want 0100", obs_req); else pass_cnt++;
      end
      if (int'(obs_reg[7:0]) > peak) peak = int'(obs_reg[7:0]);
      if (obs_rvalid) begin
        total_cnt++;
        if (sb.size() == 0) $display("FAIL b2b_rsp: got unexpected rvalid data %h want none", obs_rdata);
        else begin exp = sb.pop_front(); if (obs_rdata !== exp) $display("FAIL b2b_rsp: got %h want %h", obs_rdata, exp); else begin pass_cnt++; $display("b2b rsp %h", obs_rdata); end end
      end
    end
    s_req_i = 0;
    while (sb.size() > 0 && n < 20) begin
      tick(); n++;
      if (int'(obs_reg[7:0]) > peak) peak = int'(obs_reg[7:0]);
      if (obs_rvalid) begin
        total_cnt++; exp = sb.pop_front();
        if (obs_rdata !== exp) $display("FAIL b2b_rsp: got %h want %h", obs_rdata, exp); else begin pass_cnt++; $display("b2b rsp %h", obs_rdata); end
      end
    end
    total_cnt++; if (sb.size() != 0) $display("FAIL b2b_drain: got %0d left want 0", sb.size()); else pass_cnt++;
    total_cnt++; if (peak != 3) $display("FAIL b2b_peak: got %0d want 3", peak); else pass_cnt++;
    tick();
    total_cnt++; if (obs_reg[7:0] !== 8'd0) $display("FAIL b2b_cnt0: got %0d want 0", obs_reg[7:0]); else pass_cnt++;
  endtask

  task automatic test_switch_block();
    logic [31:0] exp;
    do_reset();
    m_gnt_i = 4'hF;
    s_req_i = 1; s_addr_i = 32'h1000;
    tick();
    total_cnt++; if ({obs_gnt, obs_req} !== 5'b1_0010) $display("FAIL sw_first: got %b want 10010", {obs_gnt, obs_req}); else pass_cnt++;
    s_addr_i = 32'h3000;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++; if ({obs_gnt, obs_req} !== 5'b0_0000) $display("FAIL sw_stall%0d: got %b want 00000", i, {obs_gnt, obs_req}); else pass_cnt++;
    end
    inject(1, chdata(32'h1000));
    tick();
    total_cnt++; if (obs_gnt !== 1'b0) $display("FAIL sw_gnt_on_rsp: got %b want 0", obs_gnt); else pass_cnt++;
    total_cnt++;
    if (!obs_rvalid || sb.size() == 0) $display("FAIL sw_rsp1: got rvalid %b want 1", obs_rvalid);
    else begin exp = sb.pop_front(); if (obs_rdata !== exp) $display("FAIL sw_rsp1: got %h want %h", obs_rdata, exp); else begin pass_cnt++; $display("sw rsp %h", obs_rdata); end end
    tick();
    total_cnt++; if ({obs_gnt, obs_req} !== 5'b1_1000) $display("FAIL sw_ch3: got %b want 11000", {obs_gnt, obs_req}); else pass_cnt++;
    s_req_i = 0;
    inject(3, chdata(32'h3000));
    tick();
    total_cnt++;
    if (!obs_rvalid || sb.size() == 0) $display("FAIL sw_rsp3: got rvalid %b want 1", obs_rvalid);
    else begin exp = sb.pop_front(); if (obs_rdata !== exp) $display("FAIL sw_rsp3: got %h want %h", obs_rdata, exp); else begin pass_cnt++; $display("sw rsp %h", obs_rdata); end end
  endtask

  task automatic test_max_outst();
    do_reset();
    m_gnt_i = 4'hF;
    s_req_i = 1; s_addr_i = 32'h0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total_cnt++;
      if (obs_gnt2 !== (i < 2)) $display("FAIL mo_gnt%0d: got %b want %b", i, obs_gnt2, (i < 2)); else pass_cnt++;
    end
    inject(0, chdata(32'h0));
    tick();
    total_cnt++; if ({obs_rvalid2, obs_gnt2} !== 2'b10) $display("FAIL mo_rsp: got rvalid,gnt %b want 10", {obs_rvalid2, obs_gnt2}); else pass_cnt++;
    total_cnt++; if (obs_rdata2 !== chdata(32'h0)) $display("FAIL mo_rdata: got %h want %h", obs_rdata2, chdata(32'h0)); else pass_cnt++;
    tick();
    total_cnt++; if (obs_gnt2 !== 1'b1) $display("FAIL mo_regnt: got %b want 1", obs_gnt2); else pass_cnt++;
    s_req_i = 0;
  endtask

  task automatic test_decode_miss();
    logic [31:0] exp;
    do_reset();
    m_gnt_i = 4'hF;
    s_req_i = 1; s_addr_i = 32'h5000;
    tick();
    total_cnt++; if ({obs_gnt, obs_req, obs_rvalid} !== 6'b1_0000_0) $display("FAIL err_gnt: got %b want 100000", {obs_gnt, obs_req, obs_rvalid}); else pass_cnt++;
    s_addr_i = 32'h7000;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (i == 0) begin
        total_cnt++; if (obs_gnt !== 1'b1) $display("FAIL err_gnt2: got %b want 1", obs_gnt); else pass_cnt++;
        s_req_i = 0;
      end
      total_cnt++;
      if (!obs_rvalid || sb.size() == 0) $display("FAIL err_rsp%0d: got rvalid %b want 1", i, obs_rvalid);
      else begin exp = sb.pop_front(); if (obs_rdata !== exp) $display("FAIL err_rsp%0d: got %h want %h", i, obs_rdata, exp); else begin pass_cnt++; $display("err rsp %h", obs_rdata); end end
    end
    tick();
    total_cnt++; if ({obs_rvalid, obs_reg[7:0]} !== 9'h0) $display("FAIL err_idle: got %h want 0", {obs_rvalid, obs_reg[7:0]}); else pass_cnt++;
  endtask

  task automatic test_irq();
    do_reset();
    reg_write(4'h4, 32'hFFFF_FFF5);
    reg_addr_i = 4'h4;
    tick();
    total_cnt++; if (obs_reg !== 32'h5) $display("FAIL irq_mask: got %h want 5", obs_reg); else pass_cnt++;
    reg_addr_i = 4'h0;
    irq_i = 4'b0001;
    tick();
    tick();
    total_cnt++; if ({obs_reg, obs_irq} !== {32'h1, 1'b0}) $display("FAIL irq_pend: got %h,%b want 1,0", obs_reg, obs_irq); else pass_cnt++;
    tick();
    total_cnt++; if (obs_irq !== 1'b1) $display("FAIL irq_out: got %b want 1", obs_irq); else pass_cnt++;
    irq_i = 4'b0000;
    tick();
    irq_i = 4'b0001;
    reg_write(4'h0, 32'h1);
    reg_addr_i = 4'h0;
    tick();
    total_cnt++; if (obs_reg !== 32'h1) $display("FAIL irq_setwins: got %h want 1", obs_reg); else pass_cnt++;
    reg_write(4'h0, 32'h1);
    reg_addr_i = 4'h0;
    tick();
    total_cnt++; if (obs_reg !== 32'h0) $display("FAIL irq_w1c: got %h want 0", obs_reg); else pass_cnt++;
    tick();
    total_cnt++; if (obs_irq !== 1'b0) $display("FAIL irq_low: got %b want 0", obs_irq); else pass_cnt++;
    irq_i = 4'b0011;
    tick();
    tick();
    total_cnt++; if ({obs_reg, obs_irq} !== {32'h2, 1'b0}) $display("FAIL irq_masked: got %h,%b want 2,0", obs_reg, obs_irq); else pass_cnt++;
    tick();
    total_cnt++; if (obs_irq !== 1'b0) $display("FAIL irq_masked2: got %b want 0", obs_irq); else pass_cnt++;
    reg_valid_i = 1; reg_addr_i = 4'hC;
    tick();
    total_cnt++; if ({obs_rerr, obs_reg} !== {1'b1, 32'h0}) $display("FAIL reg_unmapped: got %b,%h want 1,0", obs_rerr, obs_reg); else pass_cnt++;
    reg_valid_i = 0; reg_addr_i = 4'h8;
  endtask

  task automatic test_stray();
    do_reset();
    inject(3, 32'h1234_5678);
    tick();
    total_cnt++; if (obs_rvalid !== 1'b0) $display("FAIL stray_pass: got %b want 0", obs_rvalid); else pass_cnt++;
    tick();
    total_cnt++; if (obs_reg[31] !== 1'b1) $display("FAIL stray_set: got %b want 1", obs_reg[31]); else pass_cnt++;
    reg_write(4'h8, 32'h0);
    tick();
    total_cnt++; if (obs_reg[31] !== 1'b0) $display("FAIL stray_clr: got %b want 0", obs_reg[31]); else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    do_reset();
    m_gnt_i = 4'hF;
    s_req_i = 1; s_addr_i = 32'h2000;
    tick();
    s_req_i = 0;
    do_reset();
    inject(2, chdata(32'h2000));
    tick();
    total_cnt++; if (obs_rvalid !== 1'b0) $display("FAIL abort_rsp: got %b want 0", obs_rvalid); else pass_cnt++;
    tick();
    total_cnt++; if ({obs_reg[31], obs_reg[7:0]} !== 9'h100) $display("FAIL abort_status: got %h want 100", {obs_reg[31], obs_reg[7:0]}); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_switch_block();
    test_max_outst();
    test_decode_miss();
    test_irq();
    test_stray();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
